// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with a 2-entry skid buffer, flush, NOP fill and a stall counter
module pipe_stage_reg #(
    parameter int OPW = 5,
    parameter int RDW = 7,
    parameter int DW = 32,
    parameter int NDATA = 4,
    parameter logic [OPW-1:0] NOP_OPCODE = '0,
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPW-1:0]      in_opcode,
    input  logic [RDW-1:0]      in_rd,
    input  logic [NDATA*DW-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPW-1:0]      out_opcode,
    output logic [RDW-1:0]      out_rd,
    output logic [NDATA*DW-1:0] out_data,
    output logic [CNTW-1:0]     stall_cycles
);
    localparam int EW = OPW + RDW + NDATA*DW;
    typedef enum logic [1:0] {EMPTY = 2'b00, BAD = 2'b01, FULL = 2'b10, SKID = 2'b11} state_t;
    state_t state, state_nx;
    logic [EW-1:0] main_q, main_nx, skid_q, skid_nx, in_ent;
    logic [CNTW-1:0] cnt;
    logic main_valid, skid_valid, acc_in, acc_out;
    assign main_valid = state[1];
    assign skid_valid = state[0];
    assign in_ent = {in_opcode, in_rd, in_data};
    assign in_ready = ~skid_valid & ~flush;
    assign acc_in = in_valid & in_ready;
    assign out_valid = main_valid;
    assign acc_out = main_valid & out_ready;
    assign out_opcode = main_valid ? main_q[EW-1 -: OPW] : NOP_OPCODE;
    assign out_rd = main_valid ? main_q[NDATA*DW +: RDW] : '0;
    assign out_data = main_q[NDATA*DW-1:0];
    assign stall_cycles = cnt;
    always_comb begin
        state_nx = state;
        main_nx = main_q;
        skid_nx = skid_q;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    state_nx = acc_in ? FULL : EMPTY;
                    main_nx = acc_in ? in_ent : main_q;
                end
                FULL: begin
                    state_nx = acc_in ? (acc_out ? FULL : SKID) : (acc_out ? EMPTY : FULL);
                    main_nx = (acc_in && acc_out) ? in_ent : main_q;
                    skid_nx = (acc_in && !acc_out) ? in_ent : skid_q;
                end
                SKID: begin
                    state_nx = acc_out ? FULL : SKID;
                    main_nx = acc_out ? skid_q : main_q;
                    skid_nx = acc_out ? '0 : skid_q;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
            cnt <= '0;
        end else begin
            state <= state_nx;
            main_q <= main_nx;
            skid_q <= skid_nx;
            if (main_valid && !out_ready && cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end
endmodule
